// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions used by the memory stage.
//   mem_state_t        : memory-stage FSM states (IDLE, LOW, HIGH, DONE)
//   SRAM_ADDR_W        : SRAM halfword address width
//   SRAM_DATA_W        : SRAM data bus width
//   DEFAULT_BASE_ADDR  : byte address that maps to SRAM word 0
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_phase_timer.sv
// Counts the cycles of one SRAM halfword phase.
// Ports:
//   clk   in  : clock
//   rst   in  : synchronous active-high reset
//   clear in  : hold the counter at zero (asserted outside the SRAM phases)
//   last  out : high in the final cycle of a WAIT_CYCLES-long phase
// The counter wraps to zero on its own after `last`, so consecutive phases
// (LOW then HIGH) are timed without an extra clear cycle.
module sram_phase_timer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic last
);

  localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign last = (cnt == LAST_CNT);

  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_mem_stage.sv
// ARM pipeline memory stage: performs one 32-bit load or store against a
// 16-bit asynchronous SRAM as two halfword phases (low half, then high half).
// Ports:
//   clk, rst    in  : clock, synchronous active-high reset
//   mem_r_en    in  : load request (held by the frozen pipeline)
//   mem_w_en    in  : store request (held by the frozen pipeline); wins over mem_r_en
//   alu_result  in  : byte address
//   val_rm      in  : store data
//   ready       out : no access pending; ~ready freezes the pipeline
//   rd_data     out : registered load result
//   sram_addr   out : SRAM halfword address
//   sram_we_n   out : SRAM write strobe, active-low
//   sram_dq     io  : SRAM data bus, driven only during store phases
module sram_mem_stage
  import arm_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            val_rm,
  output logic                   ready,
  output logic [31:0]            rd_data,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  inout  wire  [SRAM_DATA_W-1:0] sram_dq
);

  localparam int WORD_W = SRAM_ADDR_W - 1;

  mem_state_t             state;
  mem_state_t             state_next;
  logic [WORD_W-1:0]      word;
  logic [WORD_W-1:0]      word_in;
  logic                   is_store;
  logic                   req;
  logic                   in_phase;
  logic                   phase_last;
  logic                   drive;
  logic [SRAM_DATA_W-1:0] wr_half;

  assign req      = mem_r_en | mem_w_en;
  assign in_phase = (state == LOW) || (state == HIGH);

  // Word index relative to the SRAM window; the subtraction wraps modulo 2^32
  // and the upper bits are simply dropped, so out-of-range addresses alias.
  assign word_in = WORD_W'((alu_result - BASE_ADDR) >> 2);

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(~in_phase),
    .last (phase_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = LOW;
      LOW:     if (phase_last) state_next = HIGH;
      HIGH:    if (phase_last) state_next = DONE;
      DONE:    state_next = IDLE;  // request is still held; it is not a new one
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    ready     = 1'b0;
    sram_addr = '0;
    sram_we_n = 1'b1;
    drive     = 1'b0;
    wr_half   = val_rm[SRAM_DATA_W-1:0];
    case (state)
      IDLE: ready = ~req;
      LOW: begin
        sram_addr = {word, 1'b0};
        sram_we_n = ~is_store;
        drive     = is_store;
      end
      HIGH: begin
        sram_addr = {word, 1'b1};
        sram_we_n = ~is_store;
        drive     = is_store;
        wr_half   = val_rm[31:SRAM_DATA_W];
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Store data is taken straight from val_rm: the execute stage is frozen for
  // the whole access, so it is stable without a local copy.
  assign sram_dq = drive ? wr_half : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      word     <= '0;
      is_store <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (state == IDLE && req) begin
        word     <= word_in;
        is_store <= mem_w_en;
      end
      // Capture the bus in the last cycle of each load phase, when the SRAM
      // has had the full wait time to settle.
      if (!is_store && phase_last) begin
        if (state == LOW)  rd_data[SRAM_DATA_W-1:0] <= sram_dq;
        if (state == HIGH) rd_data[31:SRAM_DATA_W]  <= sram_dq;
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_stage.sv
// Testbench for sram_mem_stage. Two instances: index 0 with WAIT_CYCLES=2,
// index 1 with WAIT_CYCLES=1. Each has its own SRAM device model. Stimulus
// pushes expected transactions into a scoreboard queue; a monitor per instance
// pops and compares when the access completes (ready rises after a low run).
module tb_sram_mem_stage;

  localparam logic [31:0] BASE = 32'd1024;

  typedef struct {
    int          k;
    int          ready_low;
    int          we_low;
    logic [16:0] word;
    logic [31:0] rd;
  } sb_t;

  logic        clk;
  logic        rst   [2];
  logic        r_en  [2];
  logic        w_en  [2];
  logic [31:0] alu   [2];
  logic [31:0] rm    [2];
  logic        ready [2];
  logic [31:0] rd    [2];
  logic [17:0] saddr [2];
  logic        we_n  [2];
  wire  [15:0] dq0;
  wire  [15:0] dq1;

  // SRAM device models and reference model
  bit   [15:0] sram [2][262144];
  int          wp_cnt [2];
  logic [17:0] wp_addr [2];
  bit   [31:0] ref_mem [bit [17:0]];
  logic [31:0] rd_exp [2];

  sb_t         sbq[$];
  logic [17:0] last_addrs[$];
  int          last_low;
  bit          trace_on;
  bit          trace[$];

  int n_checks;
  int n_fail;

  sram_mem_stage #(.WAIT_CYCLES(2), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .rst(rst[0]), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
    .alu_result(alu[0]), .val_rm(rm[0]), .ready(ready[0]), .rd_data(rd[0]),
    .sram_addr(saddr[0]), .sram_we_n(we_n[0]), .sram_dq(dq0)
  );

  sram_mem_stage #(.WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .rst(rst[1]), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
    .alu_result(alu[1]), .val_rm(rm[1]), .ready(ready[1]), .rd_data(rd[1]),
    .sram_addr(saddr[1]), .sram_we_n(we_n[1]), .sram_dq(dq1)
  );

  // SRAM output drivers: the device drives the bus whenever it is not written.
  assign dq0 = we_n[0] ? sram[0][saddr[0]] : 16'hzzzz;
  assign dq1 = we_n[1] ? sram[1][saddr[1]] : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // A write commits only after WE has been held low at one address for the
  // minimum write-pulse width (WAIT_CYCLES cycles); a truncated pulse is lost.
  task automatic sram_step(input int k, input logic wen, input logic [17:0] a, input logic [15:0] d);
    if (wen) begin
      wp_cnt[k] = 0;
    end else begin
      if (wp_cnt[k] == 0 || wp_addr[k] != a) begin
        wp_cnt[k]  = 1;
        wp_addr[k] = a;
      end else begin
        wp_cnt[k]++;
      end
      if (wp_cnt[k] == wc(k)) sram[k][a] = d;
    end
  endtask

  always @(negedge clk) begin
    sram_step(0, we_n[0], saddr[0], dq0);
    sram_step(1, we_n[1], saddr[1], dq1);
  end

  function automatic logic [31:0] ref_rd(input int k, input logic [16:0] wd);
    bit [17:0] key;
    key = {k[0], wd};
    return ref_mem.exists(key) ? ref_mem[key] : 32'd0;
  endfunction

  task automatic preload(input int k, input logic [16:0] wd, input logic [31:0] data);
    sram[k][{wd, 1'b0}] = data[15:0];
    sram[k][{wd, 1'b1}] = data[31:16];
    ref_mem[{k[0], wd}] = data;
  endtask

  function automatic logic [17:0] la(input int i);
    return (last_addrs.size() > i) ? last_addrs[i] : 18'h2AAAA;
  endfunction

  // Issue one request at posedge+1 and hold it until the access completes;
  // returns at posedge+1 of the IDLE cycle following DONE.
  task automatic issue(input int k, input bit r, input bit w, input logic [31:0] addr,
                       input logic [31:0] data);
    sb_t         e;
    logic [31:0] idx;
    logic [16:0] wd;
    bit          seen;
    idx = ((addr - BASE) / 4) % 32'h20000;
    wd  = idx[16:0];
    e.k = k;
    e.word = wd;
    e.ready_low = 2 * wc(k) + 1;
    e.we_low = w ? 2 * wc(k) : 0;
    if (w) ref_mem[{k[0], wd}] = data;
    else   rd_exp[k] = ref_rd(k, wd);
    e.rd = rd_exp[k];
    sbq.push_back(e);
    r_en[k] = r;
    w_en[k] = w;
    alu[k]  = addr;
    rm[k]   = data;
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready[k]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: inst %0d ready never rose within 50 cycles", k);
    end
    @(posedge clk);
    #1;
    if (w) begin
      check("sram_lo", {16'd0, sram[k][{wd, 1'b0}]}, {16'd0, data[15:0]});
      check("sram_hi", {16'd0, sram[k][{wd, 1'b1}]}, {16'd0, data[31:16]});
    end
  endtask

  task automatic idle(input int k, input int n);
    r_en[k] = 1'b0;
    w_en[k] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor(input int k);
    int          low_cnt;
    int          we_cnt;
    logic [17:0] addrs[$];
    sb_t         e;
    low_cnt = 0;
    we_cnt  = 0;
    forever begin
      @(negedge clk);
      if (rst[k]) begin
        low_cnt = 0;
        we_cnt  = 0;
        addrs.delete();
      end else begin
        if (trace_on && k == 0) trace.push_back(ready[0]);
        if (!we_n[k]) we_cnt++;
        if (!ready[k]) begin
          if (low_cnt > 0) addrs.push_back(saddr[k]);
          low_cnt++;
        end else if (low_cnt > 0) begin
          if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: inst %0d completed an access nobody issued", k);
          end else begin
            e = sbq.pop_front();
            check("sb_inst", k, e.k);
            check("ready_low", low_cnt, e.ready_low);
            check("we_low", we_cnt, e.we_low);
            check("rd_data", rd[k], e.rd);
            check("addr_cnt", addrs.size(), 2 * wc(k));
            for (int i = 0; i < addrs.size() && i < 2 * wc(k); i++)
              check("addr_seq", addrs[i], {e.word, (i >= wc(k)) ? 1'b1 : 1'b0});
          end
          last_addrs = addrs;
          last_low   = low_cnt;
          addrs.delete();
          low_cnt = 0;
          we_cnt  = 0;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] saved;
    logic [11:0] act_pat;
    logic [11:0] exp_pat;
    logic [31:0] a;
    logic [16:0] wd;
    int          op;
    int          sel;

    n_checks = 0;
    n_fail   = 0;
    trace_on = 1'b0;
    last_low = 0;
    for (int k = 0; k < 2; k++) begin
      rst[k]    = 1'b1;
      r_en[k]   = 1'b0;
      w_en[k]   = 1'b0;
      alu[k]    = '0;
      rm[k]     = '0;
      rd_exp[k] = '0;
      wp_cnt[k] = 0;
      wp_addr[k] = '0;
      for (int w = 0; w < 16; w++) preload(k, 17'(w), $urandom());
    end
    preload(1, 17'h1FFFF, $urandom());

    fork
      monitor(0);
      monitor(1);
    join_none

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", ready[k], 1'b1);
      check("rst_rd", rd[k], 32'd0);
      check("rst_we_n", we_n[k], 1'b1);
      check("rst_addr", saddr[k], 18'd0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;

    // Store then load, same address
    issue(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    check("hw2_beef", {16'd0, sram[0][2]}, 32'h0000BEEF);
    check("hw3_dead", {16'd0, sram[0][3]}, 32'h0000DEAD);
    idle(0, 1);
    issue(0, 1'b1, 1'b0, 32'd1028, 32'd0);
    check("load_deadbeef", rd[0], 32'hDEADBEEF);
    idle(0, 2);

    // Back-to-back loads with the ready trace
    trace.delete();
    trace_on = 1'b1;
    issue(0, 1'b1, 1'b0, 32'd1024, 32'd0);
    issue(0, 1'b1, 1'b0, 32'd1032, 32'd0);
    trace_on = 1'b0;
    idle(0, 1);
    exp_pat = '0;
    act_pat = '1;
    for (int t = 0; t < 12; t++) begin
      exp_pat[t] = ((t % 6) == 5);
      if (t < trace.size()) act_pat[t] = trace[t];
    end
    check("b2b_len", trace.size(), 12);
    check("b2b_ready", act_pat, exp_pat);
    check("b2b_word2", rd[0], ref_rd(0, 17'd2));

    // Both enables: store wins, rd_data untouched
    saved = rd_exp[0];
    issue(0, 1'b1, 1'b1, 32'd1024 + 32'd24, 32'h12345678);
    check("both_rd_hold", rd[0], saved);
    idle(0, 1);

    // Reset during the HIGH phase of a store
    preload(0, 17'd5, 32'hAAAA5555);
    w_en[0] = 1'b1;
    alu[0]  = 32'd1024 + 32'd20;
    rm[0]   = 32'h13579BDF;
    repeat (4) @(negedge clk);
    check("rst_mid_in_high", saddr[0], 18'd11);
    rst[0]  = 1'b1;
    w_en[0] = 1'b0;
    @(posedge clk);
    #1;
    check("rstm_we_n", we_n[0], 1'b1);
    check("rstm_rd", rd[0], 32'd0);
    check("rstm_ready", ready[0], 1'b1);
    check("rstm_addr", saddr[0], 18'd0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    check("rstm_lo_written", {16'd0, sram[0][10]}, 32'h00009BDF);
    check("rstm_hi_kept", {16'd0, sram[0][11]}, 32'h0000AAAA);
    ref_mem[{1'b0, 17'd5}] = 32'hAAAA9BDF;
    rd_exp[0] = '0;
    idle(0, 1);

    // Randomized traffic on the WAIT_CYCLES=2 instance
    for (int i = 0; i < 40; i++) begin
      op  = int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 7));
      wd  = 17'($urandom_range(0, 15));
      if (sel == 0)      a = $urandom();
      else if (sel == 1) a = BASE + 32'd4 * (32'h20000 + {15'd0, wd});
      else               a = BASE + 32'd4 * {15'd0, wd} + 32'($urandom_range(0, 3));
      issue(0, op != 1, (op == 1) || (op == 2), a, $urandom());
      if ($urandom_range(0, 2) != 0) idle(0, int'($urandom_range(1, 2)));
    end
    idle(0, 2);

    // WAIT_CYCLES=1: top-of-window load and address wrap
    issue(1, 1'b1, 1'b0, 32'd1024 + 32'd4 * 32'h1FFFF, 32'd0);
    check("top_addr_lo", la(0), 18'h3FFFE);
    check("top_addr_hi", la(1), 18'h3FFFF);
    check("top_ready_low", last_low, 3);
    check("top_rd", rd[1], ref_rd(1, 17'h1FFFF));
    idle(1, 1);
    issue(1, 1'b1, 1'b0, 32'd1024 + 32'd4 * 32'h20000, 32'd0);
    check("wrap_addr", la(0), 18'd0);
    check("wrap_rd", rd[1], ref_rd(1, 17'd0));
    idle(1, 1);

    for (int i = 0; i < 12; i++) begin
      op = int'($urandom_range(0, 3));
      wd = 17'($urandom_range(0, 15));
      a  = BASE + 32'd4 * {15'd0, wd};
      issue(1, op != 1, (op == 1) || (op == 2), a, $urandom());
      if ($urandom_range(0, 1) != 0) idle(1, 1);
    end
    idle(1, 5);

    check("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
